// File: rtl/int_to_float.sv
// int_to_float: signed 32-bit integer to IEEE-754 single conversion, one normalise bit per cycle.
// Define INT_TO_FLOAT_SIGN_EXT24_EN to convert 24-bit samples sign-extended from i_A[23].
module int_to_float (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [31:0] i_A,
    input  logic        i_A_STB,
    output logic        o_A_ACK,
    output logic [31:0] o_Z,
    output logic        o_Z_STB,
    input  logic        i_Z_ACK
);
    typedef enum logic [2:0] {
        S_GET_A, S_CONVERT_0, S_NORMALISE, S_ROUND, S_PACK, S_PUT_Z
    } state_t;
    state_t      r_state, w_next;
    logic [31:0] r_a, r_mag, r_z, w_a, w_mag;
    logic [23:0] r_mant, w_mant;
    logic [7:0]  r_exp;
    logic        r_sign, w_up;
`ifdef INT_TO_FLOAT_SIGN_EXT24_EN
    assign w_a = {{8{i_A[23]}}, i_A[23:0]};
`else
    assign w_a = i_A;
`endif
    assign w_mag  = r_a[31] ? (~r_a + 32'd1) : r_a;
    assign w_mant = r_mag[31:8];
    assign w_up   = r_mag[7] && (r_mag[6] || |r_mag[5:0] || w_mant[0]);
    always_ff @(posedge i_CLK) begin
        if (i_RST) r_state <= S_GET_A;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_GET_A:     w_next = (o_A_ACK && i_A_STB) ? S_CONVERT_0 : S_GET_A;
            S_CONVERT_0: w_next = (w_mag == 32'd0) ? S_PUT_Z : S_NORMALISE;
            S_NORMALISE: w_next = r_mag[31] ? S_ROUND : S_NORMALISE;
            S_ROUND:     w_next = S_PACK;
            S_PACK:      w_next = S_PUT_Z;
            S_PUT_Z:     w_next = (o_Z_STB && i_Z_ACK) ? S_GET_A : S_PUT_Z;
            default:     w_next = S_GET_A;
        endcase
    end
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            o_A_ACK <= 1'b0;
            o_Z_STB <= 1'b0;
            o_Z     <= 32'd0;
        end else begin
            case (r_state)
                S_GET_A: begin
                    o_A_ACK <= !(o_A_ACK && i_A_STB);
                    if (o_A_ACK && i_A_STB) r_a <= w_a;
                end
                S_CONVERT_0: begin
                    r_sign <= r_a[31];
                    r_mag  <= w_mag;
                    r_exp  <= 8'd158;
                    r_z    <= 32'd0;
                end
                S_NORMALISE: begin
                    if (!r_mag[31]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - 8'd1;
                    end
                end
                // an all-ones mantissa rounding up carries into the exponent
                S_ROUND: begin
                    r_mant <= w_up ? (&w_mant ? 24'h800000 : w_mant + 24'd1) : w_mant;
                    if (w_up && &w_mant) r_exp <= r_exp + 8'd1;
                end
                S_PACK: r_z <= {r_sign, r_exp, r_mant[22:0]};
                S_PUT_Z: begin
                    o_Z     <= r_z;
                    o_Z_STB <= !(o_Z_STB && i_Z_ACK);
                end
                default: o_A_ACK <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_int_to_float.sv
// tb_int_to_float: directed scoreboard bench for int_to_float, including the 24-bit sign-extension build.
module tb_int_to_float;
    logic        clk = 1'b0, rst = 1'b1, a_stb = 1'b0, z_ack = 1'b0;
    logic [31:0] a = 32'd0;
    logic        a_ack, z_stb;
    logic [31:0] z;
    logic [31:0] sb[$];
    int          checks = 0, errors = 0;

    int_to_float dut (
        .i_CLK(clk), .i_RST(rst), .i_A(a), .i_A_STB(a_stb), .o_A_ACK(a_ack),
        .o_Z(z), .o_Z_STB(z_stb), .i_Z_ACK(z_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // leading zeros of the magnitude seen by the converter, from the bench's own view of the input
    function automatic int lat_of(input logic [31:0] raw);
        logic [31:0] v, m;
        int n;
`ifdef INT_TO_FLOAT_SIGN_EXT24_EN
        v = {{8{raw[23]}}, raw[23:0]};
`else
        v = raw;
`endif
        m = v[31] ? 32'd0 - v : v;
        if (m == 32'd0) return 2;
        n = 0;
        while (!m[31 - n]) n++;
        return 5 + n;
    endfunction

    task automatic wait_ack();
        int n = 0;
        while (!a_ack && n < 10) begin
            tick();
            n++;
        end
        chk("a_ack_ready", {31'd0, a_ack}, 32'd1);
    endtask

    task automatic send(input logic [31:0] val, input logic [31:0] exp_z, input int hold);
        int cyc = 0;
        logic [31:0] held;
        wait_ack();
        a = val;
        a_stb = 1'b1;
        sb.push_back(exp_z);
        tick();
        a_stb = 1'b0;
        chk("a_ack_busy", {31'd0, a_ack}, 32'd0);
        while (!z_stb && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("latency", cyc, lat_of(val));
        chk("result", z, sb.pop_front());
        held = z;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_z", z, held);
            chk("bp_stb", {31'd0, z_stb}, 32'd1);
            chk("bp_a_ack", {31'd0, a_ack}, 32'd0);
        end
        z_ack = 1'b1;
        tick();
        z_ack = 1'b0;
        chk("stb_clear", {31'd0, z_stb}, 32'd0);
        chk("ack_wait", {31'd0, a_ack}, 32'd0);
        chk("z_retained", z, held);
        tick();
        chk("ack_rise", {31'd0, a_ack}, 32'd1);
    endtask

    initial begin
        z_ack = 1'b1;
        a_stb = 1'b1;
        tick();
        tick();
        z_ack = 1'b0;
        a_stb = 1'b0;
        chk("rst_a_ack", {31'd0, a_ack}, 32'd0);
        chk("rst_z_stb", {31'd0, z_stb}, 32'd0);
        chk("rst_z", z, 32'd0);
        rst = 1'b0;
        tick();
        chk("ack_after_rst", {31'd0, a_ack}, 32'd1);
`ifdef INT_TO_FLOAT_SIGN_EXT24_EN
        send(32'hAB800000, 32'hCB000000, 0);
        send(32'h00FFFFFF, 32'hBF800000, 0);
        send(32'hFF000000, 32'h00000000, 0);
        send(32'h12000001, 32'h3F800000, 0);
`else
        send(32'h00000001, 32'h3F800000, 0);
        send(32'hFFFFFFFF, 32'hBF800000, 0);
        send(32'h00000000, 32'h00000000, 0);
        send(32'h80000000, 32'hCF000000, 0);
        send(32'h7FFFFFFF, 32'h4F000000, 0);
        send(32'h01000001, 32'h4B800000, 0);
        send(32'h01000003, 32'h4B800002, 0);
        send(32'h00000003, 32'h40400000, 10);
`endif
        wait_ack();
        a = 32'h00000001;
        a_stb = 1'b1;
        tick();
        a_stb = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("midrst_z_stb", {31'd0, z_stb}, 32'd0);
        chk("midrst_a_ack", {31'd0, a_ack}, 32'd0);
        rst = 1'b0;
        tick();
        chk("midrst_ack_rise", {31'd0, a_ack}, 32'd1);
        send(32'h00000002, 32'h40000000, 0);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_to_float.md
INT_TO_FLOAT -- requirements
Module: int_to_float

Interface
REQ-001 SHALL have port i_CLK, input, 1 bit: single clock; all logic updates on its rising edge.
REQ-002 SHALL have port i_RST, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port i_A, input, 32 bits: signed two's-complement integer sample.
REQ-004 SHALL have port i_A_STB, input, 1 bit: i_A valid.
REQ-005 SHALL have port o_A_ACK, output reg, 1 bit: block ready to accept i_A.
REQ-006 SHALL have port o_Z, output reg, 32 bits: IEEE-754 single-precision result, feeding the float adder's i_A/i_B.
REQ-007 SHALL have port o_Z_STB, output reg, 1 bit: o_Z valid.
REQ-008 SHALL have port i_Z_ACK, input, 1 bit: consumer has taken o_Z.

Function
REQ-009 SHALL implement states get_a, convert_0, normalise, round, pack, put_z; all other encodings SHALL go to get_a.
REQ-010 In get_a: SHALL drive o_A_ACK=1; on an edge with o_A_ACK && i_A_STB, SHALL capture i_A, clear o_A_ACK and go to convert_0.
REQ-011 In convert_0: SHALL record sign = bit31 and compute magnitude |i_A| as a 32-bit unsigned value, so 0x80000000 gives 2^31.
REQ-012 In convert_0: if magnitude == 0, SHALL set z=0x00000000 (positive zero) and go directly to put_z.
REQ-013 Otherwise, convert_0 SHALL set exponent=158 (127+31) and go to normalise.
REQ-014 In normalise: while magnitude[31]==0, SHALL shift the magnitude left 1 and decrement the exponent, one bit per cycle; once bit31 is set, SHALL go to round.
REQ-015 Round field definitions: mantissa = mag[31:8], guard = mag[7], round = mag[6], sticky = |mag[5:0].
REQ-016 Round rule (nearest-even): if guard && (round | sticky | mantissa[0]), SHALL add 1 to the mantissa.
REQ-017 On round carry-out (mantissa 0xFFFFFF -> 0), SHALL set mantissa to 0x800000 and increment the exponent.
REQ-018 In pack: z = {sign, exponent[7:0], mantissa[22:0]}; no overflow, NaN or denormal paths exist (|result| <= 2^31).
REQ-019 In put_z: SHALL drive o_Z=z and o_Z_STB=1, holding both until an edge with o_Z_STB && i_Z_ACK; on that edge SHALL clear o_Z_STB and go to get_a.
REQ-020 Latency, non-zero input: with N = leading zeros of the magnitude (0..31), o_Z_STB SHALL first read 1 after edge E0+5+N, where E0 is the capture edge.
REQ-021 Latency, zero input: o_Z_STB SHALL first read 1 after edge E0+2.
REQ-022 o_A_ACK SHALL be 0 in every state except get_a; no new sample is accepted while busy.
REQ-023 o_Z SHALL retain its last value outside put_z.

Reset
REQ-024 On an edge with i_RST=1: state=get_a, o_A_ACK=0, o_Z_STB=0, o_Z=0; reset SHALL override any simultaneous handshake.
REQ-025 Reset mid-conversion SHALL discard the in-flight sample; o_A_ACK SHALL rise on the first edge after i_RST falls.

Configuration
REQ-026 With macro INT_TO_FLOAT_SIGN_EXT24_EN defined: only i_A[23:0] is used, sign-extended from bit 23 (24-bit ADC samples); i_A[31:24] is ignored.
REQ-027 Without INT_TO_FLOAT_SIGN_EXT24_EN: the full 32-bit i_A is used.

Verification
REQ-028 i_A=0x00000001 -> o_Z=0x3F800000; o_Z_STB after E0+36 (N=31).
REQ-029 i_A=0xFFFFFFFF -> 0xBF800000; i_A=0x00000000 -> 0x00000000 after E0+2; i_A=0x80000000 -> 0xCF000000.
REQ-030 Rounding: i_A=0x7FFFFFFF -> 0x4F000000 (carry-out); i_A=0x01000001 -> 0x4B800000 (tie to even); i_A=0x01000003 -> 0x4B800002.
REQ-031 Backpressure: i_Z_ACK held 0 for 10 cycles -> o_Z/o_Z_STB stable and o_A_ACK=0 throughout; one cycle after i_Z_ACK=1, o_Z_STB=0 and o_A_ACK=1 on the following edge.
REQ-032 Reset: assert i_RST during normalise -> next cycle o_Z_STB=0, o_A_ACK=0; a new sample 0x00000002 is then converted to 0x40000000.
REQ-033 With INT_TO_FLOAT_SIGN_EXT24_EN: i_A=0xAB800000 -> 0xCB000000; i_A=0x00FFFFFF -> 0xBF800000.
